gcd_initiator: RTL and testbench

GCD_INITIATOR -- requirements
Module: gcd_initiator

---
 rtl/gcd_initiator.sv | 237 +++++++++++++++++++++++
 tb/tb_gcd_initiator.sv | 603 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : gcd_initiator
// Purpose  : Batch front-end for an external GCD core. Up to four operand
//            pairs are loaded from switches, then issued one at a time to
//            the core over a Start / q_I / q_Done / Ack handshake. Results
//            are stored per entry and read back through Rd_idx / Rd_data.
//            Entries with a zero operand are never issued: their result is
//            forced to 0 and their Err bit is set.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk, Reset (async, active low)  clock / reset
//   Load, Go, Clear                 single-cycle user pulses
//   Ain_sw, Bin_sw [7:0]            operand pair captured on Load
//   Rd_idx [1:0] / Rd_data [7:0]    combinational result readback
//   Count [2:0]                     number of loaded entries (0..4)
//   Busy, Done_all, Err [3:0]       run status, per-entry error flags
//   Ain, Bin [7:0], Start, Ack      core request side
//   Core_Reset                      one-cycle core reset on WAIT timeout
//   q_I, q_Done, AB_GCD [7:0]       core status / result
// Configuration
//   GCD_INITIATOR_TIMEOUT_EN        when defined, WAIT gives up after 4095
//                                   cycles, pulses Core_Reset and flags the
//                                   entry. Undefined: WAIT waits forever.
// ============================================================================
module gcd_initiator (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic       Go,
    input  logic       Clear,
    input  logic [7:0] Ain_sw,
    input  logic [7:0] Bin_sw,
    input  logic [1:0] Rd_idx,
    output logic [7:0] Rd_data,
    output logic [2:0] Count,
    output logic       Busy,
    output logic       Done_all,
    output logic [3:0] Err,
    output logic [7:0] Ain,
    output logic [7:0] Bin,
    output logic       Start,
    output logic       Ack,
    output logic       Core_Reset,
    input  logic       q_I,
    input  logic       q_Done,
    input  logic [7:0] AB_GCD
);

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        REQ  = 6'b000010,
        WAIT = 6'b000100,
        ACK  = 6'b001000,
        NEXT = 6'b010000,
        FIN  = 6'b100000
    } state_t;

    state_t state, state_next;

    logic [7:0] ent_a [4];
    logic [7:0] ent_b [4];
    logic [7:0] res   [4];
    logic [2:0] count;
    logic [1:0] idx;
    logic [3:0] err;
    logic [7:0] ain_hold;
    logic [7:0] bin_hold;

    logic do_load, do_go, do_clear, do_issue, do_skip, do_capture, do_advance;
    logic entry_zero, last_entry, timeout;

    assign entry_zero = (ent_a[idx] == 8'd0) || (ent_b[idx] == 8'd0);
    assign last_entry = ({1'b0, idx} == (count - 3'd1));

`ifdef GCD_INITIATOR_TIMEOUT_EN
    // Counts cycles spent in WAIT; held at zero elsewhere, so it is
    // naturally zero on the first WAIT cycle.
    logic [11:0] wait_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 12'd1;
        end
    end

    assign timeout    = (state == WAIT) && !q_Done && (wait_cnt == 12'hFFF);
    assign Core_Reset = timeout;
`else
    assign timeout    = 1'b0;
    assign Core_Reset = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_go      = 1'b0;
        do_clear   = 1'b0;
        do_issue   = 1'b0;
        do_skip    = 1'b0;
        do_capture = 1'b0;
        do_advance = 1'b0;
        case (state)
            IDLE: begin
                // Clear first, then Load; Go only when neither is present.
                if (Clear) begin
                    do_clear = 1'b1;
                end else if (Load) begin
                    do_load = (count != 3'd4);
                end else if (Go && (count != 3'd0)) begin
                    do_go      = 1'b1;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (entry_zero) begin
                    do_skip    = 1'b1;
                    do_advance = 1'b1;
                end else begin
                    do_issue   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!q_I) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (q_Done) begin
                    do_capture = 1'b1;
                    state_next = ACK;
                end else if (timeout) begin
                    do_skip    = 1'b1;
                    do_advance = 1'b1;
                end
            end
            ACK: begin
                if (q_I) begin
                    do_advance = 1'b1;
                end
            end
            FIN: begin
                if (Clear) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end else if (Go && (count != 3'd0)) begin
                    do_go      = 1'b1;
                    state_next = NEXT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (do_advance) begin
            state_next = last_entry ? FIN : NEXT;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count    <= '0;
            idx      <= '0;
            err      <= '0;
            ain_hold <= '0;
            bin_hold <= '0;
            for (int i = 0; i < 4; i++) begin
                ent_a[i] <= '0;
                ent_b[i] <= '0;
                res[i]   <= '0;
            end
        end else begin
            if (do_clear) begin
                count <= '0;
                err   <= '0;
                for (int i = 0; i < 4; i++) begin
                    res[i] <= '0;
                end
            end
            if (do_load) begin
                ent_a[count[1:0]] <= Ain_sw;
                ent_b[count[1:0]] <= Bin_sw;
                count             <= count + 3'd1;
            end
            if (do_go) begin
                idx <= '0;
                err <= '0;
                for (int i = 0; i < 4; i++) begin
                    res[i] <= '0;
                end
            end
            // Operands are latched on the way into REQ and then left alone
            // until the next issue, so they are stable through ACK.
            if (do_issue) begin
                ain_hold <= ent_a[idx];
                bin_hold <= ent_b[idx];
            end
            if (do_skip) begin
                res[idx] <= '0;
                err[idx] <= 1'b1;
            end
            if (do_capture) begin
                res[idx] <= AB_GCD;
            end
            if (do_advance && !last_entry) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign Rd_data  = res[Rd_idx];
    assign Count    = count;
    assign Err      = err;
    assign Ain      = ain_hold;
    assign Bin      = bin_hold;
    assign Start    = (state == REQ);
    assign Ack      = (state == ACK);
    assign Busy     = (state == NEXT) || (state == REQ) ||
                      (state == WAIT) || (state == ACK);
    assign Done_all = (state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_gcd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_initiator
// Purpose  : Self-checking bench for gcd_initiator. A behavioural GCD core
//            answers the handshake; expected results come from a queue model
//            and a modulo-based reference GCD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_initiator;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Load = 1'b0;
    logic       Go = 1'b0;
    logic       Clear = 1'b0;
    logic [7:0] Ain_sw = 8'd0;
    logic [7:0] Bin_sw = 8'd0;
    logic [1:0] Rd_idx = 2'd0;
    wire  [7:0] Rd_data;
    wire  [2:0] Count;
    wire        Busy;
    wire        Done_all;
    wire  [3:0] Err;
    wire  [7:0] Ain;
    wire  [7:0] Bin;
    wire        Start;
    wire        Ack;
    wire        Core_Reset;
    logic       q_I;
    logic       q_Done;
    logic [7:0] AB_GCD;

    gcd_initiator dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Go(Go), .Clear(Clear),
        .Ain_sw(Ain_sw), .Bin_sw(Bin_sw), .Rd_idx(Rd_idx), .Rd_data(Rd_data),
        .Count(Count), .Busy(Busy), .Done_all(Done_all), .Err(Err),
        .Ain(Ain), .Bin(Bin), .Start(Start), .Ack(Ack), .Core_Reset(Core_Reset),
        .q_I(q_I), .q_Done(q_Done), .AB_GCD(AB_GCD)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference queue model: what the user has loaded.
    int         q_n = 0;
    logic [7:0] q_a [4];
    logic [7:0] q_b [4];

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        if (x == 8'd0 || y == 8'd0) return 8'd0;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [3:0] ref_err();
        logic [3:0] e;
        e = 4'd0;
        for (int i = 0; i < q_n; i++)
            if (q_a[i] == 8'd0 || q_b[i] == 8'd0) e[i] = 1'b1;
        return e;
    endfunction

    function automatic int ref_issues();
        int n;
        n = 0;
        for (int i = 0; i < q_n; i++)
            if (q_a[i] != 8'd0 && q_b[i] != 8'd0) n++;
        return n;
    endfunction

    // Rising-edge counter on Start.
    int   start_pulses = 0;
    logic start_prev = 1'b0;
    always @(negedge Clk) begin
        if (Start && !start_prev) start_pulses++;
        start_prev = Start;
    end

`ifdef GCD_INITIATOR_TIMEOUT_EN
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;
`endif

    // ------------------------------------------------------------------
    // Behavioural GCD core (subtractive algorithm).
    // ------------------------------------------------------------------
    bit         core_hang = 1'b0;
    int         stab_errs = 0;

    function automatic logic [7:0] sub_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y;
        x = a;
        y = b;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    initial begin
        int         phase;
        int         dly;
        logic [7:0] ca, cb;
        phase  = 0;
        dly    = 0;
        ca     = 8'd0;
        cb     = 8'd0;
        q_I    = 1'b1;
        q_Done = 1'b0;
        AB_GCD = 8'd0;
        forever begin
            @(posedge Clk);
            #2;
            if (!Reset || Core_Reset) begin
                phase  = 0;
                q_I    = 1'b1;
                q_Done = 1'b0;
            end else begin
                case (phase)
                    0: if (Start) begin
                        ca    = Ain;
                        cb    = Bin;
                        dly   = $urandom_range(0, 2);
                        phase = 1;
                    end
                    1: begin
                        if (Ain != ca || Bin != cb) stab_errs++;
                        if (dly == 0) begin
                            q_I   = 1'b0;
                            dly   = $urandom_range(0, 4);
                            phase = 2;
                        end else dly--;
                    end
                    2: begin
                        if (Ain != ca || Bin != cb) stab_errs++;
                        if (!core_hang) begin
                            if (dly == 0) begin
                                AB_GCD = sub_gcd(ca, cb);
                                q_Done = 1'b1;
                                phase  = 3;
                            end else dly--;
                        end
                    end
                    default: if (Ack) begin
                        if (Ain != ca || Bin != cb) stab_errs++;
                        q_Done = 1'b0;
                        q_I    = 1'b1;
                        phase  = 0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
        Ain_sw = a;
        Bin_sw = b;
        Load   = 1'b1;
        tick();
        Load   = 1'b0;
        if (q_n < 4) begin
            q_a[q_n] = a;
            q_b[q_n] = b;
            q_n++;
        end
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        q_n   = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (Done_all) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic go_and_wait(output bit ok);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        wait_done(ok);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        checks++;
        if ({Count, Busy, Done_all, Err, Start, Ack, Core_Reset} !== 12'd0 ||
            Ain !== 8'd0 || Bin !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: Count=%0d Busy=%b Done=%b Err=%b Start=%b Ack=%b CR=%b Ain=%0d Bin=%0d, required all 0",
                     Count, Busy, Done_all, Err, Start, Ack, Core_Reset, Ain, Bin);
        end
        for (int i = 0; i < 4; i++) begin
            Rd_idx = i[1:0];
            #1;
            checks++;
            if (Rd_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_result[%0d]: got %0d, required 0", i, Rd_data);
            end
        end
        // Go with an empty queue is ignored.
        Go = 1'b1;
        tick();
        Go = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done_all !== 1'b0) begin
            errors++;
            $display("FAIL go_empty: Busy=%b Done=%b, required 0 0", Busy, Done_all);
        end
    endtask

    task automatic test_basic();
        int p0;
        bit ok;
        load_pair(8'd12, 8'd18);
        load_pair(8'd7, 8'd5);
        p0 = start_pulses;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        checks++;
        if (Start !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_c1: Start=%b Busy=%b, required 0 1", Start, Busy);
        end
        tick();
        checks++;
        if (Start !== 1'b1) begin
            errors++;
            $display("FAIL latency_c2: Start=%b, required 1", Start);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: Done_all=%b, required 1", Done_all);
        end
        for (int i = 0; i < 2; i++) begin
            Rd_idx = i[1:0];
            #1;
            checks++;
            if (Rd_data !== ref_gcd(q_a[i], q_b[i])) begin
                errors++;
                $display("FAIL basic_result[%0d]: got %0d, required %0d", i, Rd_data, ref_gcd(q_a[i], q_b[i]));
            end
        end
        checks++;
        if (Err !== 4'b0000 || Busy !== 1'b0 || (start_pulses - p0) !== 2) begin
            errors++;
            $display("FAIL basic_status: Err=%b Busy=%b starts=%0d, required 0000 0 2",
                     Err, Busy, start_pulses - p0);
        end
    endtask

    task automatic test_zero_operand();
        int p0;
        bit ok;
        do_clear();
        load_pair(8'd0, 8'd9);
        load_pair(8'd8, 8'd4);
        p0 = start_pulses;
        go_and_wait(ok);
        checks++;
        if (!ok || Err !== 4'b0001 || (start_pulses - p0) !== 1) begin
            errors++;
            $display("FAIL zero_status: done=%b Err=%b starts=%0d, required 1 0001 1",
                     ok, Err, start_pulses - p0);
        end
        Rd_idx = 2'd0;
        #1;
        checks++;
        if (Rd_data !== 8'd0) begin
            errors++;
            $display("FAIL zero_result0: got %0d, required 0", Rd_data);
        end
        Rd_idx = 2'd1;
        #1;
        checks++;
        if (Rd_data !== 8'd4) begin
            errors++;
            $display("FAIL zero_result1: got %0d, required 4", Rd_data);
        end
    endtask

    task automatic test_full_queue();
        bit ok;
        do_clear();
        for (int i = 0; i < 5; i++)
            load_pair(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        checks++;
        if (Count !== 3'd4) begin
            errors++;
            $display("FAIL full_count: got %0d, required 4", Count);
        end
        go_and_wait(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_timeout: Done_all=%b, required 1", Done_all);
        end
        for (int i = 0; i < 4; i++) begin
            Rd_idx = i[1:0];
            #1;
            checks++;
            if (Rd_data !== ref_gcd(q_a[i], q_b[i])) begin
                errors++;
                $display("FAIL full_result[%0d]: got %0d, required %0d", i, Rd_data, ref_gcd(q_a[i], q_b[i]));
            end
        end
    endtask

    task automatic test_random();
        int p0;
        int n;
        bit ok;
        logic [7:0] a, b;
        for (int it = 0; it < 8; it++) begin
            do_clear();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 64));
                load_pair(a, b);
            end
            p0 = start_pulses;
            go_and_wait(ok);
            checks++;
            if (!ok || Count !== 3'(n) || Err !== ref_err() || (start_pulses - p0) !== ref_issues()) begin
                errors++;
                $display("FAIL rand_status[%0d]: done=%b Count=%0d Err=%b starts=%0d, required 1 %0d %b %0d",
                         it, ok, Count, Err, start_pulses - p0, n, ref_err(), ref_issues());
            end
            for (int i = 0; i < n; i++) begin
                Rd_idx = i[1:0];
                #1;
                checks++;
                if (Rd_data !== ref_gcd(q_a[i], q_b[i])) begin
                    errors++;
                    $display("FAIL rand_result[%0d][%0d]: got %0d, required %0d",
                             it, i, Rd_data, ref_gcd(q_a[i], q_b[i]));
                end
            end
        end
    endtask

    task automatic test_load_go_same_cycle();
        bit ok;
        do_clear();
        load_pair(8'd5, 8'd10);
        Ain_sw = 8'd21;
        Bin_sw = 8'd14;
        Load   = 1'b1;
        Go     = 1'b1;
        tick();
        Load   = 1'b0;
        Go     = 1'b0;
        q_a[1] = 8'd21;
        q_b[1] = 8'd14;
        q_n    = 2;
        checks++;
        if (Count !== 3'd2 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL load_go: Count=%0d Busy=%b, required 2 0", Count, Busy);
        end
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL load_go_busy: Busy=%b, required 0", Busy);
        end
        go_and_wait(ok);
        Rd_idx = 2'd1;
        #1;
        checks++;
        if (!ok || Rd_data !== 8'd7) begin
            errors++;
            $display("FAIL load_go_result1: done=%b got %0d, required 1 7", ok, Rd_data);
        end
    endtask

    task automatic test_ignored_and_rerun();
        bit ok;
        do_clear();
        load_pair(8'd48, 8'd36);
        load_pair(8'd27, 8'd81);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        // Load and Clear while busy must have no effect.
        Ain_sw = 8'd99;
        Bin_sw = 8'd33;
        Load   = 1'b1;
        tick();
        Load   = 1'b0;
        Clear  = 1'b1;
        tick();
        Clear  = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || Count !== 3'd2) begin
            errors++;
            $display("FAIL busy_ignore: done=%b Count=%0d, required 1 2", ok, Count);
        end
        // Load in FIN is ignored too.
        Load = 1'b1;
        tick();
        Load = 1'b0;
        checks++;
        if (Count !== 3'd2 || Done_all !== 1'b1) begin
            errors++;
            $display("FAIL fin_load: Count=%0d Done=%b, required 2 1", Count, Done_all);
        end
        // Go in FIN reruns the same queue.
        Go = 1'b1;
        tick();
        Go = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Done_all !== 1'b0) begin
            errors++;
            $display("FAIL rerun_start: Busy=%b Done=%b, required 1 0", Busy, Done_all);
        end
        wait_done(ok);
        for (int i = 0; i < 2; i++) begin
            Rd_idx = i[1:0];
            #1;
            checks++;
            if (!ok || Rd_data !== ref_gcd(q_a[i], q_b[i])) begin
                errors++;
                $display("FAIL rerun_result[%0d]: done=%b got %0d, required %0d",
                         i, ok, Rd_data, ref_gcd(q_a[i], q_b[i]));
            end
        end
        do_clear();
        Rd_idx = 2'd0;
        #1;
        checks++;
        if (Count !== 3'd0 || Done_all !== 1'b0 || Err !== 4'd0 || Rd_data !== 8'd0) begin
            errors++;
            $display("FAIL fin_clear: Count=%0d Done=%b Err=%b R0=%0d, required 0 0 0000 0",
                     Count, Done_all, Err, Rd_data);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit ok;
        do_clear();
        load_pair(8'd30, 8'd45);
        load_pair(8'd9, 8'd6);
        core_hang = 1'b1;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (Start) seen = 1'b1;
            else if (seen && Busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_reach_wait: reached=%b, required 1", ok);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({Count, Busy, Done_all, Err, Start, Ack, Core_Reset} !== 12'd0 ||
            Ain !== 8'd0 || Bin !== 8'd0 || Rd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: Count=%0d Busy=%b Done=%b Err=%b Start=%b Ack=%b Ain=%0d Bin=%0d, required all 0",
                     Count, Busy, Done_all, Err, Start, Ack, Ain, Bin);
        end
        tick();
        tick();
        Reset     = 1'b1;
        core_hang = 1'b0;
        q_n       = 0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Count !== 3'd0 || Ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: Busy=%b Count=%0d Ack=%b, required 0 0 0", Busy, Count, Ack);
        end
    endtask

`ifdef GCD_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        int  t_wait;
        int  t_cr;
        bit  seen;
        bit  ok;
        do_clear();
        load_pair(8'd3, 8'd6);
        load_pair(8'd10, 8'd4);
        core_hang = 1'b1;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        seen   = 1'b0;
        t_wait = -1;
        t_cr   = -1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (Start) seen = 1'b1;
            else if (seen && t_wait < 0) t_wait = cyc;
            if (Core_Reset) begin
                t_cr = cyc;
                break;
            end
        end
        core_hang = 1'b0;
        checks++;
        if (t_wait < 0 || t_cr < 0 || (t_cr - t_wait) !== 4095) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, required 4095", t_cr - t_wait);
        end
        tick();
        checks++;
        if (Core_Reset !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: Core_Reset=%b, required 0", Core_Reset);
        end
        wait_done(ok);
        Rd_idx = 2'd1;
        #1;
        checks++;
        if (!ok || Err !== 4'b0001 || Rd_data !== 8'd2) begin
            errors++;
            $display("FAIL timeout_result: done=%b Err=%b R1=%0d, required 1 0001 2", ok, Err, Rd_data);
        end
        Rd_idx = 2'd0;
        #1;
        checks++;
        if (Rd_data !== 8'd0) begin
            errors++;
            $display("FAIL timeout_result0: got %0d, required 0", Rd_data);
        end
    endtask
`endif

    initial begin
        Reset = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_zero_operand();
        test_full_queue();
        test_random();
        test_load_go_same_cycle();
        test_ignored_and_rerun();
        test_reset_mid();
`ifdef GCD_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (stab_errs !== 0) begin
            errors++;
            $display("FAIL operand_stability: %0d unstable samples, required 0", stab_errs);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
